// File: rtl/myproject_mac_pipe.sv
// Pipelined signed multiply-accumulate: register operands, multiply, accumulate.
// Emits one scaled, saturated or wrapped result per vector.
module myproject_mac_pipe #(
    parameter int A_W   = 12,
    parameter int B_W   = 8,
    parameter int ACC_W = 24,
    parameter int OUT_W = 16,
    parameter int SHIFT = 0,
    parameter int SAT   = 1
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst,
    input  logic                    ce,
    input  logic                    in_valid,
    input  logic                    in_last,
    input  logic signed [A_W-1:0]   din0,
    input  logic signed [B_W-1:0]   din1,
    output logic                    out_valid,
    output logic signed [OUT_W-1:0] dout,
    output logic                    sat_flag,
    output logic                    busy
);
    // No backpressure: a beat is taken on any ce=1 cycle with in_valid=1, and
    // out_valid is a pulse lasting one ce=1 cycle (held through ce=0) with no ready.
    localparam int PW = A_W + B_W;
    localparam logic signed [ACC_W-1:0] OUT_MAX =
        {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

    logic                    s1_v, s1_last;
    logic signed [A_W-1:0]   s1_a;
    logic signed [B_W-1:0]   s1_b;
    logic                    s2_v, s2_last;
    logic signed [ACC_W-1:0] s2_prod;
    logic signed [ACC_W-1:0] acc;
    logic                    first;

    logic signed [PW-1:0]    prod_full;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] shifted;
    logic [OUT_W-1:0]        fmt_d;
    logic                    fmt_sat;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            s1_v    <= 1'b0;
            s1_last <= 1'b0;
            s1_a    <= '0;
            s1_b    <= '0;
        end else if (ce) begin
            s1_v    <= in_valid;
            s1_last <= in_valid & in_last;
            s1_a    <= din0;
            s1_b    <= din1;
        end
    end

    assign prod_full = s1_a * s1_b;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            s2_v    <= 1'b0;
            s2_last <= 1'b0;
            s2_prod <= '0;
        end else if (ce) begin
            s2_v    <= s1_v;
            s2_last <= s1_last;
            s2_prod <= ACC_W'(prod_full);
        end
    end

    // The first beat of a vector replaces the accumulator instead of adding to it.
    always_comb begin
        sum     = first ? s2_prod : acc + s2_prod;
        shifted = sum >>> SHIFT;
        fmt_d   = shifted[OUT_W-1:0];
        fmt_sat = 1'b0;
        if (SAT != 0) begin
            if (shifted > OUT_MAX) begin
                fmt_d   = OUT_MAX[OUT_W-1:0];
                fmt_sat = 1'b1;
            end else if (shifted < OUT_MIN) begin
                fmt_d   = OUT_MIN[OUT_W-1:0];
                fmt_sat = 1'b1;
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            acc       <= '0;
            first     <= 1'b1;
            out_valid <= 1'b0;
            dout      <= '0;
            sat_flag  <= 1'b0;
        end else if (ce) begin
            out_valid <= 1'b0;
            if (s2_v) begin
                if (s2_last) begin
                    acc       <= '0;
                    first     <= 1'b1;
                    out_valid <= 1'b1;
                    dout      <= fmt_d;
                    sat_flag  <= fmt_sat;
                end else begin
                    acc   <= sum;
                    first <= 1'b0;
                end
            end
        end
    end

    assign busy = ~first;

endmodule

// File: tb/tb_myproject_mac_pipe.sv
// Bench for myproject_mac_pipe: default, wrapping and shifted instances share one
// stimulus stream; a monitor checks each instance against its own expected queue.
module tb_myproject_mac_pipe;
    localparam int EW = 49;  // {ce cycle[31:0], sat, dout[15:0]}

    logic               clk = 1'b0;
    logic               rst;
    logic               ce;
    logic               in_valid;
    logic               in_last;
    logic signed [11:0] din0;
    logic signed [7:0]  din1;
    logic               ov [3];
    logic [15:0]        dv [3];
    logic               sf [3];
    logic               bz [3];

    logic [EW-1:0] exp_q0[$];
    logic [EW-1:0] exp_q1[$];
    logic [EW-1:0] exp_q2[$];

    int n_vec  = 0;
    int n_err  = 0;
    int ce_cnt = 0;
    logic last_ce = 1'b0;

    myproject_mac_pipe dut_def (
        .ap_clk(clk), .ap_rst(rst), .ce(ce), .in_valid(in_valid), .in_last(in_last),
        .din0(din0), .din1(din1), .out_valid(ov[0]), .dout(dv[0]), .sat_flag(sf[0]), .busy(bz[0])
    );
    myproject_mac_pipe #(.SAT(0)) dut_wrap (
        .ap_clk(clk), .ap_rst(rst), .ce(ce), .in_valid(in_valid), .in_last(in_last),
        .din0(din0), .din1(din1), .out_valid(ov[1]), .dout(dv[1]), .sat_flag(sf[1]), .busy(bz[1])
    );
    myproject_mac_pipe #(.SHIFT(4), .SAT(1)) dut_shift (
        .ap_clk(clk), .ap_rst(rst), .ce(ce), .in_valid(in_valid), .in_last(in_last),
        .din0(din0), .din1(din1), .out_valid(ov[2]), .dout(dv[2]), .sat_flag(sf[2]), .busy(bz[2])
    );

    // clock / reset-independent bookkeeping
    always #5 clk = ~clk;

    always @(posedge clk) begin
        ce_cnt  <= ce_cnt + (ce ? 1 : 0);
        last_ce <= ce;
    end

    task automatic chk(input string name, input longint act, input longint req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // driver tasks: every drive happens 1 time unit after a rising edge
    task automatic send(input int a, input int b, input bit last);
        ce       = 1'b1;
        in_valid = 1'b1;
        in_last  = last;
        din0     = 12'(a);
        din1     = 8'(b);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int k, input bit ce_val);
        ce = ce_val;
        for (int i = 0; i < k; i++) begin
            in_valid = ~ce_val;
            in_last  = ce_val ? 1'b0 : 1'($urandom_range(0, 1));
            din0     = 12'($urandom_range(0, 4095));
            din1     = 8'($urandom_range(0, 255));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        ce       = 1'b1;
    endtask

    // Called right after the last beat is taken; result expected two ce edges later.
    task automatic push(input int d0, input bit s0, input int d1, input bit s1,
                        input int d2, input bit s2);
        logic [31:0] c;
        c = 32'(ce_cnt + 2);
        exp_q0.push_back({c, s0, 16'(d0)});
        exp_q1.push_back({c, s1, 16'(d1)});
        exp_q2.push_back({c, s2, 16'(d2)});
    endtask

    // scoreboard monitor
    task automatic mon(input int k);
        logic [EW-1:0] e;
        int qs;
        case (k)
            0:       qs = exp_q0.size();
            1:       qs = exp_q1.size();
            default: qs = exp_q2.size();
        endcase
        if (qs == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_out dut%0d: got dout=%0d, required no output",
                     k, $signed(dv[k]));
        end else begin
            case (k)
                0:       e = exp_q0.pop_front();
                1:       e = exp_q1.pop_front();
                default: e = exp_q2.pop_front();
            endcase
            chk($sformatf("dout dut%0d", k), longint'($signed(dv[k])), longint'($signed(e[15:0])));
            chk($sformatf("sat_flag dut%0d", k), longint'(sf[k]), longint'(e[16]));
            chk($sformatf("latency dut%0d", k), longint'(ce_cnt), longint'(e[48:17]));
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++)
            if (ov[k] && last_ce) mon(k);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish within 200000 time units");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        ce       = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        din0     = '0;
        din1     = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst out_valid dut%0d", k), longint'(ov[k]), 0);
            chk($sformatf("rst dout dut%0d", k), longint'(dv[k]), 0);
            chk($sformatf("rst sat_flag dut%0d", k), longint'(sf[k]), 0);
            chk($sformatf("rst busy dut%0d", k), longint'(bz[k]), 0);
        end
        rst = 1'b0;
        idle(2, 1'b1);

        // single beat: 100 * -3
        send(100, -3, 1'b1);
        push(-300, 1'b0, -300, 1'b0, -19, 1'b0);
        idle(4, 1'b1);

        // (1,2,3,4)x2 with a gap, busy across the vector
        send(1, 2, 1'b0);
        send(2, 2, 1'b0);
        idle(1, 1'b1);
        send(3, 2, 1'b0);
        send(4, 2, 1'b1);
        push(20, 1'b0, 20, 1'b0, 1, 1'b0);
        chk("busy mid-vector", longint'(bz[0]), 1);
        idle(2, 1'b1);
        chk("busy after last", longint'(bz[0]), 0);
        idle(2, 1'b1);

        // positive and negative saturation, sum 779907 and -780288
        repeat (2) send(2047, 127, 1'b0);
        send(2047, 127, 1'b1);
        push(32767, 1'b1, -6525, 1'b0, 32767, 1'b1);
        repeat (2) send(-2048, 127, 1'b0);
        send(-2048, 127, 1'b1);
        push(-32768, 1'b1, 6144, 1'b0, -32768, 1'b1);
        idle(4, 1'b1);

        // ce low mid-vector and in flight; pulse holds through ce=0
        send(10, -20, 1'b0);
        idle(2, 1'b0);
        send(30, 40, 1'b1);
        push(1000, 1'b0, 1000, 1'b0, 62, 1'b0);
        idle(2, 1'b0);
        idle(2, 1'b1);
        ce = 1'b0;
        @(posedge clk); #1;
        chk("out_valid held ce=0", longint'(ov[0]), 1);
        chk("dout held ce=0", longint'($signed(dv[0])), 1000);
        ce = 1'b1;
        @(posedge clk); #1;
        chk("out_valid pulse end", longint'(ov[0]), 0);
        idle(2, 1'b1);

        // back-to-back single-beat vectors
        send(5, 5, 1'b1);
        push(25, 1'b0, 25, 1'b0, 1, 1'b0);
        send(-7, 2, 1'b1);
        push(-14, 1'b0, -14, 1'b0, -1, 1'b0);
        idle(4, 1'b1);

        // reset mid-vector with a last beat still in flight
        send(9, 9, 1'b0);
        send(3, 3, 1'b0);
        idle(3, 1'b1);
        chk("busy before reset", longint'(bz[0]), 1);
        send(2, 2, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("busy after reset", longint'(bz[0]), 0);
        send(1, 1, 1'b1);
        push(1, 1'b0, 1, 1'b0, 0, 1'b0);
        idle(12, 1'b1);

        chk("drain dut0", longint'(exp_q0.size()), 0);
        chk("drain dut1", longint'(exp_q1.size()), 0);
        chk("drain dut2", longint'(exp_q2.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
